rv_arch_state: RTL and testbench
================================

RV_ARCH_STATE -- requirements
Module: rv_arch_state

Interface
REQ-001 Parameter XLEN, default 32: data width of registers, pc and read/write data.
REQ-002 Parameter NREGS, default 32: number of architectural registers; only 16 (RV32E) or 32 are legal.
REQ-003 Parameter RESET_PC, default 32'h0001_0000: pc value loaded on reset.
REQ-004 Parameter STACKADDR, default 32'h0001_0000: x2 value loaded on reset.
REQ-005 Parameter BYPASS, default 0: when 1, a same-cycle write is forwarded to the read ports.
REQ-006 Ports SHALL be exactly:
  clk  in  1  clock, all state updates on rising edge
  reset  in  1  synchronous, active-high
  retire  in  1  current instruction completes this cycle
  pc_next  in  XLEN  next pc, sampled when retire=1
  pc  out  XLEN  current pc
  rs1_addr  in  5  read port 1 address
  rs2_addr  in  5  read port 2 address
  rs1_rdata  out  XLEN  read port 1 data
  rs2_rdata  out  XLEN  read port 2 data
  rd_valid  in  1  write request
  rd_addr  in  5  write address
  rd_wdata  in  XLEN  write data
  cycle  out  64  cycle counter
  instret  out  64  retired-instruction counter
  halted  out  1  sticky fault stop
  fault_misalign  out  1  sticky: pc_next not 4-byte aligned
  fault_reg  out  1  sticky: register address >= NREGS

Function
REQ-007 Reads SHALL be combinational; address 0 SHALL read 0.
REQ-008 Read address >= NREGS SHALL return 0 and SHALL set fault_reg and halted on the next edge.
REQ-009 With BYPASS=1, rd_valid=1, nonzero rd_addr equal to rsN_addr, and no block per REQ-010: rsN_rdata SHALL equal rd_wdata in the same cycle; with BYPASS=0 the old value SHALL be returned.
REQ-010 A write SHALL occur at the edge when rd_valid=1, halted=0, reset=0, rd_addr!=0 and rd_addr<NREGS.
REQ-011 Writes to x0 SHALL be silently dropped with no fault.
REQ-012 rd_valid=1 with rd_addr>=NREGS SHALL drop the write and set fault_reg and halted.
REQ-013 Writes SHALL be independent of retire; a write with retire=0 still commits.
REQ-014 When retire=1 and halted=0 with pc_next[1:0]==0: pc <= pc_next and instret <= instret+1.
REQ-015 When retire=1 and halted=0 with pc_next[1:0]!=0: pc holds, instret holds, fault_misalign and halted set.
REQ-016 A misaligned retire SHALL NOT block a same-cycle legal register write.
REQ-017 cycle SHALL increment by 1 every edge with reset=0, including while halted.
REQ-018 cycle and instret SHALL be 64 bits for any XLEN and wrap from all-ones to 0 without flagging.
REQ-019 While halted=1, pc, register contents and instret SHALL be frozen.
REQ-020 Read ports SHALL remain functional while halted=1.
REQ-021 halted, fault_misalign and fault_reg SHALL clear only on reset.
REQ-022 Multiple faults in one cycle SHALL set every applicable flag.

Reset
REQ-023 On reset=1 at an edge:
  - pc=RESET_PC, x2=STACKADDR, all other registers=0
  - cycle=0, instret=0, halted=0, all fault flags=0
REQ-024 Reset SHALL override a simultaneous write, including to x2, and a simultaneous retire.
REQ-025 Outputs SHALL hold reset values on the first edge after reset deasserts; counting and writes resume from that edge.

Verification
REQ-026 Reset, then retire with pc_next=0x10004 for 3 cycles -> pc=0x10004, instret=3, cycle=3.
REQ-027 rd_valid=1, rd_addr=5, rd_wdata=0xDEADBEEF, rs1_addr=5:
  - BYPASS=1: rs1_rdata=0xDEADBEEF that cycle
  - BYPASS=0: rs1_rdata=0 that cycle, 0xDEADBEEF next cycle
REQ-028 Write 0x1234 to x0 -> rs1_rdata at address 0 = 0, fault_reg=0.
REQ-029 NREGS=16, write rd_addr=20 -> write dropped; fault_reg=1, halted=1.
  - next retire does not change pc or instret
  - cycle still increments
REQ-030 retire with pc_next=0x10006 -> fault_misalign=1, pc unchanged; then reset -> all flags 0, pc=0x10000, x2=0x10000.
REQ-031 Preload cycle near wrap (force or long run) -> 0xFFFF_FFFF_FFFF_FFFF advances to 0; write to x2 concurrent with reset -> x2=STACKADDR.

Source files
------------

// File: rtl/rv_arch_state.sv
// Architectural state for a small RISC-V core: register file, pc,
// cycle/instret counters and sticky fault/halt flags.
module rv_arch_state #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     NREGS     = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0001_0000),
   parameter logic [XLEN-1:0] STACKADDR = XLEN'(32'h0001_0000),
   parameter bit              BYPASS    = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            retire,
   input  logic [XLEN-1:0] pc_next,
   output logic [XLEN-1:0] pc,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_rdata,
   output logic [XLEN-1:0] rs2_rdata,
   input  logic            rd_valid,
   input  logic [4:0]      rd_addr,
   input  logic [XLEN-1:0] rd_wdata,
   output logic [63:0]     cycle,
   output logic [63:0]     instret,
   output logic            halted,
   output logic            fault_misalign,
   output logic            fault_reg
);

   // Only RV32E (16) and RV32I (32) register counts are meaningful.
   if (NREGS != 16 && NREGS != 32) begin : g_bad_nregs
      $error("rv_arch_state: NREGS must be 16 or 32");
   end

   localparam int unsigned LP_IW    = $clog2(NREGS);
   localparam logic [5:0]  LP_NREGS = 6'(NREGS);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [XLEN-1:0]  r_pc;
   logic [63:0]      r_cycle;
   logic [63:0]      r_instret;
   logic             r_halted;
   logic             r_fault_misalign;
   logic             r_fault_reg;

   logic             w_rs1_oob;
   logic             w_rs2_oob;
   logic             w_rd_oob;
   logic [LP_IW-1:0] w_rs1_idx;
   logic [LP_IW-1:0] w_rs2_idx;
   logic [LP_IW-1:0] w_rd_idx;
   logic [XLEN-1:0]  w_rs1_old;
   logic [XLEN-1:0]  w_rs2_old;
   logic             w_wr_en;
   logic             w_retire_ok;
   logic             w_misalign;
   logic             w_reg_fault;

   assign w_rs1_oob = ({1'b0, rs1_addr} >= LP_NREGS);
   assign w_rs2_oob = ({1'b0, rs2_addr} >= LP_NREGS);
   assign w_rd_oob  = ({1'b0, rd_addr}  >= LP_NREGS);
   assign w_rs1_idx = rs1_addr[LP_IW-1:0];
   assign w_rs2_idx = rs2_addr[LP_IW-1:0];
   assign w_rd_idx  = rd_addr[LP_IW-1:0];

   // x0 and out-of-range addresses read as zero
   assign w_rs1_old = (rs1_addr == 5'd0 || w_rs1_oob) ? '0 : r_regs[w_rs1_idx];
   assign w_rs2_old = (rs2_addr == 5'd0 || w_rs2_oob) ? '0 : r_regs[w_rs2_idx];

   // A write commits only when nothing blocks it; retire does not matter.
   assign w_wr_en     = rd_valid && !r_halted && !reset && (rd_addr != 5'd0) && !w_rd_oob;
   assign w_retire_ok = retire && !r_halted && (pc_next[1:0] == 2'b00);
   assign w_misalign  = retire && !r_halted && (pc_next[1:0] != 2'b00);
   assign w_reg_fault = w_rs1_oob || w_rs2_oob || (rd_valid && w_rd_oob);

   // Read ports, optionally forwarding the write being committed this cycle
   always_comb begin
      rs1_rdata = w_rs1_old;
      rs2_rdata = w_rs2_old;
      if (BYPASS && w_wr_en && (rd_addr == rs1_addr)) rs1_rdata = rd_wdata;
      if (BYPASS && w_wr_en && (rd_addr == rs2_addr)) rs2_rdata = rd_wdata;
   end

   // Register file: reset loads the stack pointer, otherwise one write port
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            r_regs[i] <= (i == 2) ? STACKADDR : '0;
         end
      end else if (w_wr_en) begin
         r_regs[w_rd_idx] <= rd_wdata;
      end
   end

   // Program counter and retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_instret <= '0;
      end else if (w_retire_ok) begin
         r_pc      <= pc_next;
         r_instret <= r_instret + 64'd1;
      end
   end

   // Free-running cycle counter, keeps counting while halted
   always_ff @(posedge clk) begin
      if (reset) r_cycle <= '0;
      else       r_cycle <= r_cycle + 64'd1;
   end

   // Sticky fault flags; any fault also halts
   always_ff @(posedge clk) begin
      if (reset) begin
         r_halted         <= 1'b0;
         r_fault_misalign <= 1'b0;
         r_fault_reg      <= 1'b0;
      end else begin
         if (w_misalign)                r_fault_misalign <= 1'b1;
         if (w_reg_fault)               r_fault_reg      <= 1'b1;
         if (w_misalign || w_reg_fault) r_halted         <= 1'b1;
      end
   end

   assign pc             = r_pc;
   assign cycle          = r_cycle;
   assign instret        = r_instret;
   assign halted         = r_halted;
   assign fault_misalign = r_fault_misalign;
   assign fault_reg      = r_fault_reg;

endmodule

// File: tb/tb_rv_arch_state.sv
// Scoreboard bench for rv_arch_state: three instances (no bypass, bypass,
// RV32E) share stimulus; expectations are queued per cycle and compared by
// a monitor that samples mid-cycle, after inputs settle and before the edge.
module tb_rv_arch_state;

   typedef enum int unsigned {K_PC, K_RS1, K_RS2, K_CYC, K_INSTRET, K_HALT, K_FMIS, K_FREG} kind_e;

   typedef struct {
      int unsigned due;
      int unsigned d;
      kind_e       k;
      logic [63:0] v;
      string       name;
   } exp_t;

   localparam int unsigned ALL = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        retire = 1'b0;
   logic [31:0] pc_next = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic        rd_valid = 1'b0;
   logic [4:0]  rd_addr = '0;
   logic [31:0] rd_wdata = '0;

   logic [31:0] pc_o    [3];
   logic [31:0] rs1_o   [3];
   logic [31:0] rs2_o   [3];
   logic [63:0] cyc_o   [3];
   logic [63:0] inst_o  [3];
   logic        halt_o  [3];
   logic        fmis_o  [3];
   logic        freg_o  [3];

   exp_t        q [$];
   int unsigned pcyc = 0;
   int unsigned total = 0;
   int unsigned passed = 0;

   always #5 clk = ~clk;

   always @(posedge clk) pcyc <= pcyc + 1;

   rv_arch_state #(.BYPASS(1'b0), .NREGS(32)) u0 (
      .clk(clk), .reset(reset), .retire(retire), .pc_next(pc_next), .pc(pc_o[0]),
      .rs1_addr(rs1), .rs2_addr(rs2), .rs1_rdata(rs1_o[0]), .rs2_rdata(rs2_o[0]),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .cycle(cyc_o[0]), .instret(inst_o[0]), .halted(halt_o[0]),
      .fault_misalign(fmis_o[0]), .fault_reg(freg_o[0]));

   rv_arch_state #(.BYPASS(1'b1), .NREGS(32)) u1 (
      .clk(clk), .reset(reset), .retire(retire), .pc_next(pc_next), .pc(pc_o[1]),
      .rs1_addr(rs1), .rs2_addr(rs2), .rs1_rdata(rs1_o[1]), .rs2_rdata(rs2_o[1]),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .cycle(cyc_o[1]), .instret(inst_o[1]), .halted(halt_o[1]),
      .fault_misalign(fmis_o[1]), .fault_reg(freg_o[1]));

   rv_arch_state #(.BYPASS(1'b0), .NREGS(16)) u2 (
      .clk(clk), .reset(reset), .retire(retire), .pc_next(pc_next), .pc(pc_o[2]),
      .rs1_addr(rs1), .rs2_addr(rs2), .rs1_rdata(rs1_o[2]), .rs2_rdata(rs2_o[2]),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .cycle(cyc_o[2]), .instret(inst_o[2]), .halted(halt_o[2]),
      .fault_misalign(fmis_o[2]), .fault_reg(freg_o[2]));

   function automatic logic [63:0] got(int unsigned d, kind_e k);
      case (k)
         K_PC:      return {32'b0, pc_o[d]};
         K_RS1:     return {32'b0, rs1_o[d]};
         K_RS2:     return {32'b0, rs2_o[d]};
         K_CYC:     return cyc_o[d];
         K_INSTRET: return inst_o[d];
         K_HALT:    return {63'b0, halt_o[d]};
         K_FMIS:    return {63'b0, fmis_o[d]};
         default:   return {63'b0, freg_o[d]};
      endcase
   endfunction

   // queue an expectation for the current cycle, for one instance or all
   task automatic ex(int unsigned d, kind_e k, logic [63:0] v, string n);
      exp_t e;
      e.due = pcyc; e.k = k; e.v = v; e.name = n;
      if (d == ALL) begin
         for (int unsigned i = 0; i < 3; i++) begin
            e.d = i;
            q.push_back(e);
         end
      end else begin
         e.d = d;
         q.push_back(e);
      end
   endtask

   // advance to the next cycle with all inputs idle
   task automatic step();
      @(negedge clk);
      reset = 1'b0; retire = 1'b0; pc_next = '0; rs1 = '0; rs2 = '0;
      rd_valid = 1'b0; rd_addr = '0; rd_wdata = '0;
   endtask

   // monitor: compare every expectation due this cycle
   initial begin : monitor
      exp_t        e;
      logic [63:0] g;
      forever begin
         @(negedge clk);
         #3;
         while (q.size() > 0 && q[0].due <= pcyc) begin
            e = q.pop_front();
            total++;
            if (e.due != pcyc) begin
               $display("FAIL %s dut%0d: stale, due cycle %0d seen at %0d", e.name, e.d, e.due, pcyc);
            end else begin
               g = got(e.d, e.k);
               if (g === e.v) passed++;
               else $display("FAIL %s dut%0d: got %h expected %h", e.name, e.d, g, e.v);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      step(); reset = 1'b1;
      step(); reset = 1'b1; rs1 = 5'd2;
      ex(ALL, K_PC, 64'h10000, "rst_pc");     ex(ALL, K_CYC, 0, "rst_cycle");
      ex(ALL, K_INSTRET, 0, "rst_instret");   ex(ALL, K_HALT, 0, "rst_halt");
      ex(ALL, K_FMIS, 0, "rst_fmis");         ex(ALL, K_FREG, 0, "rst_freg");
      ex(ALL, K_RS1, 64'h10000, "rst_x2");    ex(ALL, K_RS2, 0, "rst_x0");

      // three aligned retires
      step(); retire = 1'b1; pc_next = 32'h10004;
      ex(ALL, K_CYC, 0, "first_cycle_hold"); ex(ALL, K_PC, 64'h10000, "first_pc_hold");
      step(); retire = 1'b1; pc_next = 32'h10004;
      ex(ALL, K_INSTRET, 1, "instret_1");
      step(); retire = 1'b1; pc_next = 32'h10004;
      step();
      ex(ALL, K_PC, 64'h10004, "ret_pc"); ex(ALL, K_INSTRET, 3, "ret_instret"); ex(ALL, K_CYC, 3, "ret_cycle");

      // write x5 without retire; bypass vs. no bypass
      step(); rd_valid = 1'b1; rd_addr = 5'd5; rd_wdata = 32'hDEADBEEF; rs1 = 5'd5;
      ex(0, K_RS1, 0, "nobyp_same"); ex(1, K_RS1, 64'hDEADBEEF, "byp_same"); ex(2, K_RS1, 0, "nobyp16_same");
      step(); rs1 = 5'd5;
      ex(ALL, K_RS1, 64'hDEADBEEF, "x5_next");

      // write to x0 dropped, no fault, never forwarded
      step(); rd_valid = 1'b1; rd_addr = 5'd0; rd_wdata = 32'h1234; rs1 = 5'd0; rs2 = 5'd5;
      ex(ALL, K_RS1, 0, "x0_nobyp"); ex(ALL, K_RS2, 64'hDEADBEEF, "rs2_x5");
      step();
      ex(ALL, K_RS1, 0, "x0_read"); ex(ALL, K_FREG, 0, "x0_nofault"); ex(ALL, K_HALT, 0, "x0_nohalt");

      // retire plus write, bypass on port 2
      step(); retire = 1'b1; pc_next = 32'h10008; rd_valid = 1'b1; rd_addr = 5'd7;
      rd_wdata = 32'hA5A50007; rs1 = 5'd5; rs2 = 5'd7;
      ex(ALL, K_RS1, 64'hDEADBEEF, "rs1_x5");
      ex(0, K_RS2, 0, "rs2_nobyp"); ex(1, K_RS2, 64'hA5A50007, "rs2_byp"); ex(2, K_RS2, 0, "rs2_nobyp16");

      // misaligned retire with a legal write in the same cycle
      step(); retire = 1'b1; pc_next = 32'h10006; rd_valid = 1'b1; rd_addr = 5'd3;
      rd_wdata = 32'h33; rs1 = 5'd7; rs2 = 5'd3;
      ex(ALL, K_PC, 64'h10008, "pc_10008"); ex(ALL, K_INSTRET, 4, "instret_4");
      ex(ALL, K_RS1, 64'hA5A50007, "x7"); ex(ALL, K_FMIS, 0, "fmis_pre");
      ex(0, K_RS2, 0, "x3_nobyp"); ex(1, K_RS2, 64'h33, "x3_byp"); ex(2, K_RS2, 0, "x3_nobyp16");

      // halted: retire and write blocked, reads still work
      step(); retire = 1'b1; pc_next = 32'h1000C; rd_valid = 1'b1; rd_addr = 5'd4;
      rd_wdata = 32'h44; rs1 = 5'd3; rs2 = 5'd4;
      ex(ALL, K_FMIS, 1, "fmis_set"); ex(ALL, K_HALT, 1, "halt_mis"); ex(ALL, K_FREG, 0, "freg_clear");
      ex(ALL, K_PC, 64'h10008, "pc_hold_mis"); ex(ALL, K_INSTRET, 4, "instret_hold_mis");
      ex(ALL, K_RS1, 64'h33, "write_with_misalign"); ex(ALL, K_RS2, 0, "halt_nobyp");
      ex(ALL, K_CYC, 10, "cycle_10");
      step(); rs1 = 5'd4; rs2 = 5'd3;
      ex(ALL, K_RS1, 0, "halt_write_blocked"); ex(ALL, K_RS2, 64'h33, "halt_read");
      ex(ALL, K_PC, 64'h10008, "halt_pc"); ex(ALL, K_INSTRET, 4, "halt_instret");
      ex(ALL, K_CYC, 11, "halt_cycle_runs"); ex(ALL, K_HALT, 1, "halt_sticky");

      // reset overrides write to x2 and retire
      step(); reset = 1'b1; retire = 1'b1; pc_next = 32'h20000; rd_valid = 1'b1;
      rd_addr = 5'd2; rd_wdata = 32'hBAD;
      ex(ALL, K_CYC, 12, "cycle_12"); ex(ALL, K_HALT, 1, "halt_before_rst");
      step(); rs1 = 5'd2; rs2 = 5'd5;
      ex(ALL, K_PC, 64'h10000, "rst2_pc"); ex(ALL, K_CYC, 0, "rst2_cycle");
      ex(ALL, K_INSTRET, 0, "rst2_instret"); ex(ALL, K_HALT, 0, "rst2_halt");
      ex(ALL, K_FMIS, 0, "rst2_fmis"); ex(ALL, K_FREG, 0, "rst2_freg");
      ex(ALL, K_RS1, 64'h10000, "rst2_x2"); ex(ALL, K_RS2, 0, "rst2_x5");

      // write to x20: legal for 32 regs, fault for 16 regs
      step(); rd_valid = 1'b1; rd_addr = 5'd20; rd_wdata = 32'h77;
      ex(ALL, K_CYC, 1, "cycle_1"); ex(2, K_FREG, 0, "freg16_pre");
      step(); retire = 1'b1; pc_next = 32'h10004;
      ex(2, K_FREG, 1, "freg16_set"); ex(2, K_HALT, 1, "halt16_set"); ex(2, K_FMIS, 0, "fmis16_clear");
      ex(0, K_FREG, 0, "freg32_clear"); ex(0, K_HALT, 0, "halt32_clear"); ex(1, K_HALT, 0, "halt32b_clear");
      step(); rs1 = 5'd20;
      ex(2, K_PC, 64'h10000, "pc16_frozen"); ex(2, K_INSTRET, 0, "instret16_frozen");
      ex(ALL, K_CYC, 3, "cycle_3");
      ex(0, K_PC, 64'h10004, "pc32_ret"); ex(1, K_INSTRET, 1, "instret32_ret");
      ex(0, K_RS1, 64'h77, "x20_32"); ex(1, K_RS1, 64'h77, "x20_32b"); ex(2, K_RS1, 0, "x20_16_zero");

      // out-of-range read faults on the next edge
      step(); reset = 1'b1;
      step();
      ex(2, K_HALT, 0, "rst3_halt16"); ex(2, K_FREG, 0, "rst3_freg16");
      step(); rs2 = 5'd17;
      ex(2, K_RS2, 0, "rd_oob_zero"); ex(2, K_HALT, 0, "rd_oob_prehalt"); ex(0, K_RS2, 0, "x17_reset");
      step();
      ex(2, K_FREG, 1, "rd_oob_freg"); ex(2, K_HALT, 1, "rd_oob_halt");
      ex(0, K_FREG, 0, "rd32_nofault"); ex(0, K_HALT, 0, "rd32_nohalt");

      // two faults in one cycle set both flags
      step(); reset = 1'b1;
      step(); retire = 1'b1; pc_next = 32'h10002; rd_valid = 1'b1; rd_addr = 5'd31; rd_wdata = 32'h99;
      ex(ALL, K_HALT, 0, "rst4_halt");
      step(); rs1 = 5'd31;
      ex(ALL, K_FMIS, 1, "multi_fmis"); ex(ALL, K_HALT, 1, "multi_halt");
      ex(2, K_FREG, 1, "multi_freg16"); ex(0, K_FREG, 0, "multi_freg32"); ex(1, K_FREG, 0, "multi_freg32b");
      ex(0, K_RS1, 64'h99, "x31_written"); ex(1, K_RS1, 64'h99, "x31_writtenb"); ex(2, K_RS1, 0, "x31_16_zero");
      ex(ALL, K_PC, 64'h10000, "multi_pc"); ex(ALL, K_INSTRET, 0, "multi_instret");

      // cycle counter wrap from all-ones
      step(); reset = 1'b1;
      step();
      force u0.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
      force u1.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
      force u2.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release u0.r_cycle;
      release u1.r_cycle;
      release u2.r_cycle;
      ex(ALL, K_CYC, 64'hFFFF_FFFF_FFFF_FFFF, "cycle_max");
      step();
      ex(ALL, K_CYC, 0, "cycle_wrap"); ex(ALL, K_HALT, 0, "wrap_nohalt"); ex(ALL, K_INSTRET, 0, "wrap_instret");
      step();
      ex(ALL, K_CYC, 1, "cycle_after_wrap");

      step();
      step();
      #5;
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         $display("FAIL %s dut%0d: never compared, expected %h", e.name, e.d, e.v);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
